// File: rtl/aidc_lite_code_buf_ctrl.sv
// Ping-pong code buffer: addressed writes fill one bank while the other drains over valid/ready.
// Optional block/word statistics ports are enabled with `define AIDC_LITE_CODE_BUF_STATS_EN.
module aidc_lite_code_buf_ctrl #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid_i,
    input  logic [3:0]        wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              done_i,
    output logic              blk_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic [4:0]        out_words_o,
`ifdef AIDC_LITE_CODE_BUF_STATS_EN
    output logic [15:0]       blk_cnt_o,
    output logic [31:0]       word_cnt_o,
`endif
    output logic              overflow_o
);
    localparam int DEPTH = 16;

    typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_DRAINING} bank_state_e;

    bank_state_e       state_q [2];
    bank_state_e       state_d [2];
    logic [4:0]        words_q [2];
    logic [4:0]        words_d [2];
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [3:0]        max_addr_q, max_addr_d;
    logic [4:0]        rd_idx_q, rd_idx_d;
    logic              done_q, blk_ready_q, blk_ready_d, overflow_q, overflow_d;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [4:0]        out_words_q, out_words_d;
    logic [DATA_W-1:0] mem_q [2][DEPTH];

    logic              wr_ok, wr_fire, done_edge, rd_bank_v;
    logic [3:0]        max_new;
    logic [4:0]        rd_idx_v;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves a latch behind.
        state_d     = state_q;
        words_d     = words_q;
        wr_bank_d   = wr_bank_q;
        max_addr_d  = max_addr_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_words_d = out_words_q;

        wr_ok     = (state_q[wr_bank_q] == ST_EMPTY) || (state_q[wr_bank_q] == ST_FILLING);
        wr_fire   = wr_valid_i && wr_ok;
        done_edge = !done_q && done_i;
        max_new   = (wr_fire && (wr_addr_i > max_addr_q)) ? wr_addr_i : max_addr_q;

        if (wr_valid_i && !wr_ok) overflow_d = 1'b1;
        if (wr_fire) begin
            state_d[wr_bank_q] = ST_FILLING;
            max_addr_d         = max_new;
        end
        // A done edge only closes a block that has at least one word in it.
        if (done_edge && (wr_fire || (state_q[wr_bank_q] == ST_FILLING))) begin
            state_d[wr_bank_q] = ST_FULL;
            words_d[wr_bank_q] = {1'b0, max_new} + 5'd1;
            wr_bank_d          = ~wr_bank_q;
            max_addr_d         = '0;
        end

        // Retire the current block first so the other bank can load in the same cycle.
        rd_bank_v = rd_bank_q;
        rd_idx_v  = rd_idx_q;
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                state_d[rd_bank_q] = ST_EMPTY;
                rd_bank_v          = ~rd_bank_q;
                rd_idx_v           = '0;
            end
        end
        rd_bank_d = rd_bank_v;
        rd_idx_d  = rd_idx_v;
        if ((!out_valid_q || out_ready_i) &&
            ((state_q[rd_bank_v] == ST_FULL) || (state_q[rd_bank_v] == ST_DRAINING)) &&
            (rd_idx_v < words_q[rd_bank_v])) begin
            out_valid_d        = 1'b1;
            out_data_d         = mem_q[rd_bank_v][rd_idx_v[3:0]];
            out_last_d         = (rd_idx_v == (words_q[rd_bank_v] - 5'd1));
            out_words_d        = words_q[rd_bank_v];
            state_d[rd_bank_v] = ST_DRAINING;
            rd_idx_d           = rd_idx_v + 5'd1;
        end

        blk_ready_d = (state_d[wr_bank_d] == ST_EMPTY) || (state_d[wr_bank_d] == ST_FILLING);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0]  <= ST_EMPTY;
            state_q[1]  <= ST_EMPTY;
            words_q[0]  <= '0;
            words_q[1]  <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            max_addr_q  <= '0;
            rd_idx_q    <= '0;
            done_q      <= 1'b1;
            blk_ready_q <= 1'b1;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_words_q <= '0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            max_addr_q  <= max_addr_d;
            rd_idx_q    <= rd_idx_d;
            done_q      <= done_i;
            blk_ready_q <= blk_ready_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_words_q <= out_words_d;
        end
    end

    // NOTE: the bank memory has no reset; bank state alone decides which words are meaningful.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_bank_q][wr_addr_i] <= wr_data_i;
    end

`ifdef AIDC_LITE_CODE_BUF_STATS_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;
    logic [31:0] word_cnt_q, word_cnt_d;

    always_comb begin
        blk_cnt_d  = blk_cnt_q;
        word_cnt_d = word_cnt_q;
        if (out_valid_q && out_ready_i) begin
            word_cnt_d = word_cnt_q + 32'd1;
            if (out_last_q) blk_cnt_d = blk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            blk_cnt_q  <= blk_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign blk_cnt_o  = blk_cnt_q;
    assign word_cnt_o = word_cnt_q;
`endif

    assign blk_ready_o = blk_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_words_o = out_words_q;
    assign overflow_o  = overflow_q;
endmodule

// File: tb/tb_aidc_lite_code_buf_ctrl.sv
// Directed bench for the ping-pong code buffer: a vector table for a single block,
// then hand-written sequences for ping-pong, backpressure, overflow, reordering and reset.
module tb_aidc_lite_code_buf_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid_i;
    logic [3:0]  wr_addr_i;
    logic [63:0] wr_data_i;
    logic        done_i;
    logic        blk_ready_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_data_o;
    logic        out_last_o;
    logic [4:0]  out_words_o;
    logic        overflow_o;
`ifdef AIDC_LITE_CODE_BUF_STATS_EN
    logic [15:0] blk_cnt_o;
    logic [31:0] word_cnt_o;
`endif

    aidc_lite_code_buf_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid_i  (wr_valid_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .done_i      (done_i),
        .blk_ready_o (blk_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_words_o (out_words_o),
`ifdef AIDC_LITE_CODE_BUF_STATS_EN
        .blk_cnt_o   (blk_cnt_o),
        .word_cnt_o  (word_cnt_o),
`endif
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_valid;
        logic [3:0]  wr_addr;
        logic [63:0] wr_data;
        logic        done;
        logic        ready;
        logic        exp_valid;
        logic [63:0] exp_data;
        logic        exp_last;
        logic [4:0]  exp_words;
        logic        exp_blk_ready;
        logic        chk_all;
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t vecs [10];
    logic [63:0] exp_data [$];
    logic        exp_last [$];
    logic [4:0]  exp_words [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic dn);
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_data_i  = d;
        done_i     = dn;
        cyc();
        wr_valid_i = 1'b0;
    endtask

    task automatic end_done();
        done_i = 1'b0;
        cyc();
    endtask

    task automatic push_blk(input logic [63:0] base, input int n);
        for (int j = 0; j < n; j++) begin
            exp_data.push_back(base + 64'(j));
            exp_last.push_back(j == n - 1);
            exp_words.push_back(5'(n));
        end
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (!out_valid_o && n < maxc) begin
            cyc();
            n++;
        end
        check("wait_valid", 64'(out_valid_o), 64'd1);
    endtask

    task automatic drain(input bit no_bubble, input int maxc);
        int  i = 0;
        int  n = 0;
        bit  started = 1'b0;
        out_ready_i = 1'b1;
        while (i < exp_data.size() && n < maxc) begin
            if (out_valid_o) begin
                started = 1'b1;
                check("drain_data", out_data_o, exp_data[i]);
                check("drain_last", 64'(out_last_o), 64'(exp_last[i]));
                check("drain_words", 64'(out_words_o), 64'(exp_words[i]));
                i++;
            end else if (started && no_bubble) begin
                check("drain_bubble", 64'(out_valid_o), 64'd1);
            end
            cyc();
            n++;
        end
        check("drain_count", 64'(i), 64'(exp_data.size()));
        exp_data.delete();
        exp_last.delete();
        exp_words.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bp_data;
        logic        r_seq [7];
        int          idx;

        // Single block, addr 0..3, done edge on the last write, ready held high.
        //          wv  a    data                   dn  rdy ev  exp_data               el  ew    br  all
        vecs[0] = '{1, 4'd0, 64'hA0A0_0000_0000_0000, 0, 1, 0, 64'h0,                  0, 5'd0, 1, 1};
        vecs[1] = '{1, 4'd1, 64'hA0A0_0000_0000_0001, 0, 1, 0, 64'h0,                  0, 5'd0, 1, 0};
        vecs[2] = '{1, 4'd2, 64'hA0A0_0000_0000_0002, 0, 1, 0, 64'h0,                  0, 5'd0, 1, 0};
        vecs[3] = '{1, 4'd3, 64'hA0A0_0000_0000_0003, 1, 1, 0, 64'h0,                  0, 5'd0, 1, 0};
        vecs[4] = '{0, 4'd0, 64'h0,                   1, 1, 0, 64'h0,                  0, 5'd0, 1, 0};
        vecs[5] = '{0, 4'd0, 64'h0,                   1, 1, 1, 64'hA0A0_0000_0000_0000, 0, 5'd4, 1, 0};
        vecs[6] = '{0, 4'd0, 64'h0,                   1, 1, 1, 64'hA0A0_0000_0000_0001, 0, 5'd4, 1, 0};
        vecs[7] = '{0, 4'd0, 64'h0,                   1, 1, 1, 64'hA0A0_0000_0000_0002, 0, 5'd4, 1, 0};
        vecs[8] = '{0, 4'd0, 64'h0,                   1, 1, 1, 64'hA0A0_0000_0000_0003, 1, 5'd4, 1, 0};
        vecs[9] = '{0, 4'd0, 64'h0,                   1, 1, 0, 64'h0,                  0, 5'd0, 1, 0};

        rst_n = 1'b0; wr_valid_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        done_i = 1'b0; out_ready_i = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            check($sformatf("vec%0d_valid", k), 64'(out_valid_o), 64'(vecs[k].exp_valid));
            check($sformatf("vec%0d_blk_ready", k), 64'(blk_ready_o), 64'(vecs[k].exp_blk_ready));
            if (vecs[k].exp_valid || vecs[k].chk_all) begin
                check($sformatf("vec%0d_data", k), out_data_o, vecs[k].exp_data);
                check($sformatf("vec%0d_last", k), 64'(out_last_o), 64'(vecs[k].exp_last));
                check($sformatf("vec%0d_words", k), 64'(out_words_o), 64'(vecs[k].exp_words));
                check($sformatf("vec%0d_overflow", k), 64'(overflow_o), 64'd0);
            end
            wr_valid_i  = vecs[k].wr_valid;
            wr_addr_i   = vecs[k].wr_addr;
            wr_data_i   = vecs[k].wr_data;
            done_i      = vecs[k].done;
            out_ready_i = vecs[k].ready;
            cyc();
        end
        wr_valid_i = 1'b0;
        end_done();

        // Ping-pong: X (2 words) then Y (16 words) with the sink stalled, then a dropped third block.
        out_ready_i = 1'b0;
        wr(4'd0, 64'h1111_0000_0000_0000, 1'b0);
        wr(4'd1, 64'h1111_0000_0000_0001, 1'b1);
        end_done();
        for (int j = 0; j < 16; j++) wr(4'(j), 64'h2222_0000_0000_0000 + 64'(j), j == 15);
        end_done();
        cyc();
        check("pp_blk_ready_low", 64'(blk_ready_o), 64'd0);
        check("pp_hold_x0", out_data_o, 64'h1111_0000_0000_0000);
        check("pp_no_overflow_yet", 64'(overflow_o), 64'd0);
        wr(4'd0, 64'h3333_0000_0000_0000, 1'b0);
        wr(4'd1, 64'h3333_0000_0000_0001, 1'b1);
        end_done();
        check("ovf_sticky", 64'(overflow_o), 64'd1);
        check("ovf_blk_ready_low", 64'(blk_ready_o), 64'd0);
        push_blk(64'h1111_0000_0000_0000, 2);
        push_blk(64'h2222_0000_0000_0000, 16);
        drain(1'b1, 60);
        for (int j = 0; j < 4; j++) begin
            check("pp_idle_after", 64'(out_valid_o), 64'd0);
            cyc();
        end
        check("pp_blk_ready_back", 64'(blk_ready_o), 64'd1);
        check("ovf_still_set", 64'(overflow_o), 64'd1);

        // Backpressure on a 3-word block: ready 1,0,0,1 then held high.
        out_ready_i = 1'b0;
        for (int j = 0; j < 3; j++) wr(4'(j), 64'hB000_0000_0000_0000 + 64'(j), j == 2);
        end_done();
        wait_valid(10);
        r_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            out_ready_i = r_seq[k];
            if (out_valid_o) begin
                bp_data = 64'hB000_0000_0000_0000 + 64'(idx);
                check("bp_data", out_data_o, bp_data);
                check("bp_last", 64'(out_last_o), 64'(idx == 2));
                check("bp_words", 64'(out_words_o), 64'd3);
                if (out_ready_i) idx++;
            end
            cyc();
        end
        check("bp_accepted", 64'(idx), 64'd3);
        check("bp_idle", 64'(out_valid_o), 64'd0);

        // Out-of-order writes: addr 2,0,1 come out in address order.
        out_ready_i = 1'b0;
        wr(4'd2, 64'hC000_0000_0000_0002, 1'b0);
        wr(4'd0, 64'hC000_0000_0000_0000, 1'b0);
        wr(4'd1, 64'hC000_0000_0000_0001, 1'b1);
        end_done();
        push_blk(64'hC000_0000_0000_0000, 3);
        drain(1'b1, 20);

`ifdef AIDC_LITE_CODE_BUF_STATS_EN
        check("stats_blk_cnt", 64'(blk_cnt_o), 64'd5);
        check("stats_word_cnt", 64'(word_cnt_o), 64'd28);
`endif

        // Asynchronous reset while word 5 of a 16-word block is presented.
        out_ready_i = 1'b0;
        for (int j = 0; j < 16; j++) wr(4'(j), 64'hD000_0000_0000_0000 + 64'(j), j == 15);
        end_done();
        wait_valid(10);
        out_ready_i = 1'b1;
        repeat (5) cyc();
        check("rst_pre_word5", out_data_o, 64'hD000_0000_0000_0005);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_data", out_data_o, 64'd0);
        check("rst_last", 64'(out_last_o), 64'd0);
        check("rst_words", 64'(out_words_o), 64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_blk_ready", 64'(blk_ready_o), 64'd1);
        for (int j = 0; j < 5; j++) begin
            check("rst_no_partial_drain", 64'(out_valid_o), 64'd0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
